// File: rtl/cam_pingpong_tx_ctrl.sv
// cam_pingpong_tx_ctrl: double-buffered pixel capture into two RAM banks with
// in-order packet dispatch and an end-of-frame marker packet.
`timescale 1ns/1ps
`default_nettype none

module cam_pingpong_tx_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 11,
    parameter int HDR_LEN     = 50,
    parameter int PAYLOAD_LEN = 1280,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              frame_done,
    input  logic              eth_finish,
    output logic              ram_we,
    output logic              ram_bank,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              send_start,
    output logic              send_bank,
    output logic              send_marker,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [1:0]        wr_state,
    output logic [1:0]        tx_state
);

    localparam logic [1:0] WR_FILL  = 2'd0;
    localparam logic [1:0] WR_STALL = 2'd1;
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_WAIT  = 2'd2;

    localparam logic [ADDR_W-1:0] C_WP_FIRST = ADDR_W'(HDR_LEN);
    localparam logic [ADDR_W-1:0] C_WP_LAST  = ADDR_W'(HDR_LEN + PAYLOAD_LEN - 1);
    localparam int                C_SUM_W    = CNT_W + ADDR_W + 1;

    logic [1:0]        r_wr_state, w_wr_next;
    logic [1:0]        r_tx_state, w_tx_next;
    logic              r_wb, r_rb, r_marker_pend;
    logic [1:0]        r_full;
    logic [ADDR_W-1:0] r_wp;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_send_bank, r_send_marker;
    logic              r_ram_we, r_ram_bank;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;

    logic              w_fill_px, w_bank_done, w_tx_done, w_release;
    logic [1:0]        w_full_clr, w_full_set, w_full_eff;
    logic [ADDR_W:0]   w_drop_add;
    logic [C_SUM_W-1:0] w_drop_sum;

    assign w_fill_px   = (r_wr_state == WR_FILL) && pix_valid;
    assign w_bank_done = w_fill_px && (r_wp == C_WP_LAST);
    assign w_tx_done   = (r_tx_state == TX_WAIT) && eth_finish;
    assign w_release   = w_tx_done && !r_send_marker;
    assign w_full_clr  = w_release   ? (2'b01 << r_rb) : 2'b00;
    assign w_full_set  = w_bank_done ? (2'b01 << r_wb) : 2'b00;
    // A bank freed by the sender this cycle is already usable by the writer.
    assign w_full_eff  = r_full & ~w_full_clr;

    always_comb begin
        w_drop_add = '0;
        if ((r_wr_state == WR_STALL) && pix_valid) begin
            w_drop_add = (ADDR_W+1)'(1);
        end else if ((r_wr_state == WR_FILL) && frame_done && !w_bank_done) begin
            w_drop_add = {1'b0, r_wp - C_WP_FIRST} + (ADDR_W+1)'(w_fill_px);
        end
    end

    assign w_drop_sum = C_SUM_W'(r_drop_cnt) + C_SUM_W'(w_drop_add);

    // Writer FSM
    always_ff @(posedge clk) begin
        if (!reset) r_wr_state <= WR_FILL;
        else        r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_FILL:  if (w_bank_done && w_full_eff[!r_wb]) w_wr_next = WR_STALL;
            WR_STALL: if (frame_done && !w_full_eff[r_wb])  w_wr_next = WR_FILL;
            default:  w_wr_next = WR_FILL;
        endcase
    end

    // Sender FSM
    always_ff @(posedge clk) begin
        if (!reset) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (r_full[r_rb] || r_marker_pend) w_tx_next = TX_START;
            TX_START: w_tx_next = TX_WAIT;
            TX_WAIT:  if (eth_finish) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        send_start = (r_tx_state == TX_START);
        wr_state   = r_wr_state;
        tx_state   = r_tx_state;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ram_we      <= 1'b0;
            r_ram_bank    <= 1'b0;
            r_ram_addr    <= C_WP_FIRST;
            r_ram_din     <= '0;
            r_wp          <= C_WP_FIRST;
            r_wb          <= 1'b0;
            r_rb          <= 1'b0;
            r_full        <= 2'b00;
            r_marker_pend <= 1'b0;
            r_drop_cnt    <= '0;
            r_send_bank   <= 1'b0;
            r_send_marker <= 1'b0;
        end else begin
            r_ram_we <= w_fill_px;
            if (w_fill_px) begin
                r_ram_bank <= r_wb;
                r_ram_addr <= r_wp;
                r_ram_din  <= cam_data;
            end
            if (w_bank_done || ((r_wr_state == WR_FILL) && frame_done)) r_wp <= C_WP_FIRST;
            else if (w_fill_px)                                          r_wp <= r_wp + 1'b1;
            r_wb   <= r_wb ^ w_bank_done;
            r_full <= w_full_eff | w_full_set;
            if (w_release) r_rb <= ~r_rb;
            if (frame_done)                      r_marker_pend <= 1'b1;
            else if (w_tx_done && r_send_marker) r_marker_pend <= 1'b0;
            r_drop_cnt <= (|w_drop_sum[C_SUM_W-1:CNT_W]) ? '1 : w_drop_sum[CNT_W-1:0];
            // Data always wins over a pending marker.
            if (r_tx_state == TX_IDLE) begin
                if (r_full[r_rb]) begin
                    r_send_marker <= 1'b0;
                    r_send_bank   <= r_rb;
                end else if (r_marker_pend) begin
                    r_send_marker <= 1'b1;
                end
            end
        end
    end

    assign ram_we      = r_ram_we;
    assign ram_bank    = r_ram_bank;
    assign ram_addr    = r_ram_addr;
    assign ram_din     = r_ram_din;
    assign send_bank   = r_send_bank;
    assign send_marker = r_send_marker;
    assign drop_cnt    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cam_pingpong_tx_ctrl.sv
// tb_cam_pingpong_tx_ctrl: directed stimulus with a queue scoreboard for RAM writes
// and send_start pulses, plus direct checks of counters and FSM states.
`timescale 1ns/1ps
`default_nettype none

module tb_cam_pingpong_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  cam_data = 8'd0;
    logic        frame_done = 1'b0;
    logic        eth_finish = 1'b0;
    logic        ram_we, ram_bank, send_start, send_bank, send_marker;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic [15:0] drop_cnt;
    logic [1:0]  wr_state, tx_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [19:0] wq[$];   // {bank, addr, data}
    logic [1:0]  sq[$];   // {marker, bank}

    cam_pingpong_tx_ctrl dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .cam_data(cam_data),
        .frame_done(frame_done), .eth_finish(eth_finish),
        .ram_we(ram_we), .ram_bank(ram_bank), .ram_addr(ram_addr), .ram_din(ram_din),
        .send_start(send_start), .send_bank(send_bank), .send_marker(send_marker),
        .drop_cnt(drop_cnt), .wr_state(wr_state), .tx_state(tx_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic pv, input logic [7:0] d, input logic fd, input logic ef);
        pix_valid  = pv;
        cam_data   = d;
        frame_done = fd;
        eth_finish = ef;
        @(posedge clk);
        #1;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        eth_finish = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic fill(input logic bk, input int a0, input int n, input logic fd, input logic ef);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = 8'((a0 - 50 + i) % 256);
            wq.push_back({bk, 11'(a0 + i), d});
            cyc(1'b1, d, (i == n-1) ? fd : 1'b0, (i == n-1) ? ef : 1'b0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ram"},   {12'd0, ram_we, ram_bank, ram_addr, ram_din}, {12'd0, 1'b0, 1'b0, 11'd50, 8'd0});
        chk({tag, "_send"},  {29'd0, send_start, send_bank, send_marker}, 32'd0);
        chk({tag, "_drop"},  {16'd0, drop_cnt}, 32'd0);
        chk({tag, "_state"}, {28'd0, wr_state, tx_state}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        reset = 1'b1;

        fork
            begin : monitor
                logic [19:0] e;
                logic [1:0]  s;
                forever begin
                    @(negedge clk);
                    if (ram_we === 1'b1) begin
                        if (wq.size() == 0) begin
                            vec_cnt++; err_cnt++;
                            $display("FAIL unexpected_write: got bank %0d addr %0d data 0x%0h, expected no write",
                                     ram_bank, ram_addr, ram_din);
                        end else begin
                            e = wq.pop_front();
                            chk("write", {12'd0, ram_bank, ram_addr, ram_din}, {12'd0, e});
                        end
                    end
                    if (send_start === 1'b1) begin
                        if (sq.size() == 0) begin
                            vec_cnt++; err_cnt++;
                            $display("FAIL unexpected_send_start: got marker %0d bank %0d, expected no pulse",
                                     send_marker, send_bank);
                        end else begin
                            s = sq.pop_front();
                            chk("send", {30'd0, send_marker, send_marker ? 1'b0 : send_bank},
                                        {30'd0, s[1], s[1] ? 1'b0 : s[0]});
                        end
                    end
                end
            end
        join_none

        // Bank 0 fill and send latency
        sq.push_back(2'b00);
        fill(1'b0, 50, 1280, 1'b0, 1'b0);
        idle(1);
        chk("start_latency", {31'd0, send_start}, 32'd1);

        // Bank 1 fills while bank 0 is still in flight, then overflow
        fill(1'b1, 50, 1280, 1'b0, 1'b0);
        chk("stall_enter", {30'd0, wr_state}, 32'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("drop_10", {16'd0, drop_cnt}, 32'd10);
        chk("stall_hold", {30'd0, wr_state}, 32'd1);
        chk("tx_wait_b0", {30'd0, tx_state}, 32'd2);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("stall_fd_full", {30'd0, wr_state}, 32'd1);
        sq.push_back(2'b01);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("stall_freed_no_fd", {30'd0, wr_state}, 32'd1);
        idle(3);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("stall_exit", {30'd0, wr_state}, 32'd0);

        // Partial frame discard and marker
        fill(1'b0, 50, 300, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("drop_310", {16'd0, drop_cnt}, 32'd310);
        wq.push_back({1'b0, 11'd50, 8'hAA});
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        sq.push_back(2'b10);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle(2);

        // Last pixel, frame_done and eth_finish together
        sq.push_back(2'b00);
        fill(1'b0, 51, 1279, 1'b0, 1'b0);
        sq.push_back(2'b01);
        sq.push_back(2'b10);
        fill(1'b1, 50, 1280, 1'b1, 1'b1);
        chk("same_cycle_no_stall", {30'd0, wr_state}, 32'd0);
        chk("same_cycle_no_drop", {16'd0, drop_cnt}, 32'd310);
        idle(4);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle(4);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle(3);

        // Reset in the middle of a transfer
        sq.push_back(2'b00);
        fill(1'b0, 50, 1280, 1'b0, 1'b0);
        idle(4);
        chk("tx_wait_pre_reset", {30'd0, tx_state}, 32'd2);
        reset = 1'b0;
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        chk_reset_vals("midreset");
        reset = 1'b1;
        idle(20);
        chk("post_reset_idle", {28'd0, wr_state, tx_state}, 32'd0);
        wq.push_back({1'b0, 11'd50, 8'h5A});
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(2);

        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("sends_outstanding", 32'(sq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
